// File: rtl/axi4_lite_reg_arbiter.sv
// rtl/axi4_lite_reg_arbiter.sv - round-robin serialiser of AXI4-Lite read/write requests onto one register port
module axi4_lite_reg_arbiter #(
  parameter int addr_width     = 7,
  parameter int data_width     = 32,
  parameter int timeout_cycles = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_req,
  input  logic [addr_width-1:0]   wr_addr,
  input  logic [data_width-1:0]   wr_data,
  input  logic [data_width/8-1:0] wr_strb,
  output logic                    wr_ready,
  output logic                    wr_response,
  input  logic                    rd_req,
  input  logic [addr_width-1:0]   rd_addr,
  output logic                    rd_ready,
  output logic                    rd_response,
  output logic [data_width-1:0]   rd_value,
  output logic                    reg_req,
  output logic                    reg_we,
  output logic [addr_width-1:0]   reg_addr,
  output logic [data_width-1:0]   reg_wdata,
  output logic [data_width/8-1:0] reg_wstrb,
  input  logic                    reg_ack,
  input  logic                    reg_err,
  input  logic [data_width-1:0]   reg_rdata
);

  localparam int strb_width = data_width / 8;
  localparam int cnt_width  = (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
  localparam bit timeout_en = (timeout_cycles > 0);
  localparam logic [cnt_width-1:0] cnt_last =
    cnt_width'((timeout_cycles > 0) ? timeout_cycles - 1 : 0);

  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

  state_t                  state, state_next;
  logic                    grant_wr, grant_wr_next;
  logic                    last_wr;
  logic                    wr_pend, rd_pend;
  logic [addr_width-1:0]   wr_addr_q, rd_addr_q;
  logic [data_width-1:0]   wr_data_q;
  logic [strb_width-1:0]   wr_strb_q;
  logic [cnt_width-1:0]    cnt;
  logic                    timeout_hit;
  logic                    start;
  logic                    wr_accept, rd_accept;

  assign timeout_hit = timeout_en && (cnt == cnt_last);
  assign start       = (state == IDLE) && (state_next == ACCESS);
  assign reg_req     = (state == ACCESS);
  assign wr_ready    = (state == RESPOND) && grant_wr;
  assign rd_ready    = (state == RESPOND) && !grant_wr;
  // a req is taken when the side is free, or in the very cycle its ready clears it
  assign wr_accept   = wr_req && (!wr_pend || wr_ready);
  assign rd_accept   = rd_req && (!rd_pend || rd_ready);

  // state and granted-side registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant_wr <= 1'b0;
    end else begin
      state    <= state_next;
      grant_wr <= grant_wr_next;
    end
  end

  // next state and grant selection; ties go opposite to the last served side
  always_comb begin
    state_next    = state;
    grant_wr_next = grant_wr;
    case (state)
      IDLE: begin
        if (wr_pend && rd_pend) begin
          grant_wr_next = !last_wr;
          state_next    = ACCESS;
        end else if (wr_pend) begin
          grant_wr_next = 1'b1;
          state_next    = ACCESS;
        end else if (rd_pend) begin
          grant_wr_next = 1'b0;
          state_next    = ACCESS;
        end
      end
      ACCESS:  if (reg_ack || timeout_hit) state_next = RESPOND;
      RESPOND: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // request capture, backend drive, timeout counter and response latching
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_pend     <= 1'b0;
      rd_pend     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_strb_q   <= '0;
      rd_addr_q   <= '0;
      last_wr     <= 1'b1;
      cnt         <= '0;
      reg_we      <= 1'b0;
      reg_addr    <= '0;
      reg_wdata   <= '0;
      reg_wstrb   <= '0;
      wr_response <= 1'b0;
      rd_response <= 1'b0;
      rd_value    <= '0;
    end else begin
      if (wr_accept) begin
        wr_pend   <= 1'b1;
        wr_addr_q <= wr_addr;
        wr_data_q <= wr_data;
        wr_strb_q <= wr_strb;
      end else if (wr_ready) begin
        wr_pend <= 1'b0;
      end

      if (rd_accept) begin
        rd_pend   <= 1'b1;
        rd_addr_q <= rd_addr;
      end else if (rd_ready) begin
        rd_pend <= 1'b0;
      end

      if (start) begin
        cnt       <= '0;
        reg_we    <= grant_wr_next;
        reg_addr  <= grant_wr_next ? wr_addr_q : rd_addr_q;
        reg_wdata <= grant_wr_next ? wr_data_q : '0;
        reg_wstrb <= grant_wr_next ? wr_strb_q : '0;
      end

      if (state == ACCESS) begin
        if (reg_ack) begin
          if (grant_wr) begin
            wr_response <= reg_err;
          end else begin
            rd_response <= reg_err;
            rd_value    <= reg_rdata;
          end
        end else if (timeout_hit) begin
          if (grant_wr) begin
            wr_response <= 1'b1;
          end else begin
            rd_response <= 1'b1;
            rd_value    <= '0;
          end
        end else if (cnt != '1) begin
          cnt <= cnt + 1'b1;
        end
      end

      if (state == RESPOND) begin
        last_wr <= grant_wr;
      end
    end
  end

endmodule

// File: tb/tb_axi4_lite_reg_arbiter.sv
// tb/tb_axi4_lite_reg_arbiter.sv - directed self-checking bench for axi4_lite_reg_arbiter
module tb_axi4_lite_reg_arbiter;

  logic        clk;
  logic        rst;
  logic        wr_req, rd_req, reg_ack, reg_err;
  logic [6:0]  wr_addr, rd_addr, reg_addr;
  logic [31:0] wr_data, rd_value, reg_wdata, reg_rdata;
  logic [3:0]  wr_strb, reg_wstrb;
  logic        wr_ready, wr_response, rd_ready, rd_response, reg_req, reg_we;

  logic        t_wr_req, t_rd_req, t_reg_ack, t_reg_err;
  logic [6:0]  t_wr_addr, t_rd_addr, t_reg_addr;
  logic [31:0] t_wr_data, t_rd_value, t_reg_wdata, t_reg_rdata;
  logic [3:0]  t_wr_strb, t_reg_wstrb;
  logic        t_wr_ready, t_wr_response, t_rd_ready, t_rd_response, t_reg_req, t_reg_we;

  int passed = 0;
  int total  = 0;
  int both_hi = 0;
  int wr_pulses = 0;

  axi4_lite_reg_arbiter dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
    .wr_ready(wr_ready), .wr_response(wr_response),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_response(rd_response), .rd_value(rd_value),
    .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_wstrb(reg_wstrb), .reg_ack(reg_ack), .reg_err(reg_err), .reg_rdata(reg_rdata)
  );

  axi4_lite_reg_arbiter #(.timeout_cycles(4)) dut_to (
    .clk(clk), .rst(rst),
    .wr_req(t_wr_req), .wr_addr(t_wr_addr), .wr_data(t_wr_data), .wr_strb(t_wr_strb),
    .wr_ready(t_wr_ready), .wr_response(t_wr_response),
    .rd_req(t_rd_req), .rd_addr(t_rd_addr), .rd_ready(t_rd_ready),
    .rd_response(t_rd_response), .rd_value(t_rd_value),
    .reg_req(t_reg_req), .reg_we(t_reg_we), .reg_addr(t_reg_addr), .reg_wdata(t_reg_wdata),
    .reg_wstrb(t_reg_wstrb), .reg_ack(t_reg_ack), .reg_err(t_reg_err), .reg_rdata(t_reg_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_ready && rd_ready) both_hi++;
    if (t_wr_ready && t_rd_ready) both_hi++;
    if (wr_ready) wr_pulses++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    wr_req = 0; rd_req = 0; reg_ack = 0; reg_err = 0; reg_rdata = '0;
    wr_addr = '0; wr_data = '0; wr_strb = '0; rd_addr = '0;
    t_wr_req = 0; t_rd_req = 0; t_reg_ack = 0; t_reg_err = 0; t_reg_rdata = '0;
    t_wr_addr = '0; t_wr_data = '0; t_wr_strb = '0; t_rd_addr = '0;
    tick; tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    total++; if ({reg_req, reg_we, reg_addr, reg_wdata, reg_wstrb} !== '0)
      $display("FAIL reset_reg got=%0h exp=0", {reg_req, reg_we, reg_addr, reg_wdata, reg_wstrb}); else passed++;
    total++; if ({wr_ready, wr_response, rd_ready, rd_response, rd_value} !== '0)
      $display("FAIL reset_resp got=%0h exp=0", {wr_ready, wr_response, rd_ready, rd_response, rd_value}); else passed++;
    total++; if ({t_reg_req, t_rd_ready, t_wr_ready} !== 3'b000)
      $display("FAIL reset_to got=%0h exp=0", {t_reg_req, t_rd_ready, t_wr_ready}); else passed++;
  endtask

  task automatic test_write;
    wr_req = 1; wr_addr = 7'h04; wr_data = 32'h12345678; wr_strb = 4'hF;
    tick;
    wr_req = 0;
    total++; if (reg_req !== 1'b0) $display("FAIL wr_pend_no_req got=%0h exp=0", reg_req); else passed++;
    tick;
    total++; if ({reg_req, reg_we, reg_addr} !== {1'b1, 1'b1, 7'h04})
      $display("FAIL wr_access got=%0h exp=%0h", {reg_req, reg_we, reg_addr}, {1'b1, 1'b1, 7'h04}); else passed++;
    total++; if ({reg_wdata, reg_wstrb} !== {32'h12345678, 4'hF})
      $display("FAIL wr_payload got=%0h exp=%0h", {reg_wdata, reg_wstrb}, {32'h12345678, 4'hF}); else passed++;
    reg_ack = 1; reg_err = 0;
    tick;
    reg_ack = 0;
    total++; if ({wr_ready, wr_response, rd_ready, reg_req} !== 4'b1000)
      $display("FAIL wr_ready got=%0b exp=1000", {wr_ready, wr_response, rd_ready, reg_req}); else passed++;
    tick;
    total++; if ({wr_ready, wr_response} !== 2'b00)
      $display("FAIL wr_ready_pulse got=%0b exp=00", {wr_ready, wr_response}); else passed++;
  endtask

  task automatic test_read;
    rd_req = 1; rd_addr = 7'h08;
    tick;
    rd_req = 0;
    tick;
    total++; if ({reg_req, reg_we, reg_addr, reg_wstrb} !== {1'b1, 1'b0, 7'h08, 4'h0})
      $display("FAIL rd_access got=%0h exp=%0h", {reg_req, reg_we, reg_addr, reg_wstrb}, {1'b1, 1'b0, 7'h08, 4'h0}); else passed++;
    repeat (5) tick;
    total++; if ({reg_req, rd_ready} !== 2'b10)
      $display("FAIL rd_wait got=%0b exp=10", {reg_req, rd_ready}); else passed++;
    reg_ack = 1; reg_rdata = 32'hCAFEF00D;
    tick;
    reg_ack = 0; reg_rdata = 32'h0BADBEEF;
    total++; if ({rd_ready, rd_response, wr_ready} !== 3'b100)
      $display("FAIL rd_ready got=%0b exp=100", {rd_ready, rd_response, wr_ready}); else passed++;
    total++; if (rd_value !== 32'hCAFEF00D) $display("FAIL rd_value got=%0h exp=cafef00d", rd_value); else passed++;
    tick; tick;
    total++; if ({rd_ready, rd_value} !== {1'b0, 32'hCAFEF00D})
      $display("FAIL rd_value_hold got=%0h exp=%0h", {rd_ready, rd_value}, {1'b0, 32'hCAFEF00D}); else passed++;
  endtask

  task automatic test_tie;
    do_reset;
    wr_req = 1; wr_addr = 7'h10; wr_data = 32'hA5A5A5A5; wr_strb = 4'h3;
    rd_req = 1; rd_addr = 7'h14;
    tick;
    wr_req = 0; rd_req = 0;
    tick;
    total++; if ({reg_req, reg_we, reg_addr} !== {1'b1, 1'b0, 7'h14})
      $display("FAIL tie1_read_first got=%0h exp=%0h", {reg_req, reg_we, reg_addr}, {1'b1, 1'b0, 7'h14}); else passed++;
    reg_ack = 1; reg_rdata = 32'h00000001;
    tick;
    reg_ack = 0;
    total++; if ({rd_ready, wr_ready} !== 2'b10) $display("FAIL tie1_rd_ready got=%0b exp=10", {rd_ready, wr_ready}); else passed++;
    // repeat the tie: new read accepted on its own ready, write still pending
    rd_req = 1; rd_addr = 7'h18;
    wr_req = 1; wr_addr = 7'h1C; wr_data = 32'hFFFFFFFF;
    tick;
    rd_req = 0; wr_req = 0;
    tick;
    total++; if ({reg_req, reg_we, reg_addr, reg_wdata} !== {1'b1, 1'b1, 7'h10, 32'hA5A5A5A5})
      $display("FAIL tie2_write_first got=%0h exp=%0h", {reg_req, reg_we, reg_addr, reg_wdata}, {1'b1, 1'b1, 7'h10, 32'hA5A5A5A5}); else passed++;
    reg_ack = 1;
    tick;
    reg_ack = 0;
    total++; if ({wr_ready, rd_ready} !== 2'b10) $display("FAIL tie2_wr_ready got=%0b exp=10", {wr_ready, rd_ready}); else passed++;
    tick; tick;
    total++; if ({reg_req, reg_we, reg_addr} !== {1'b1, 1'b0, 7'h18})
      $display("FAIL tie2_read_second got=%0h exp=%0h", {reg_req, reg_we, reg_addr}, {1'b1, 1'b0, 7'h18}); else passed++;
    reg_ack = 1; reg_rdata = 32'h11112222;
    tick;
    reg_ack = 0;
    total++; if ({rd_ready, rd_value} !== {1'b1, 32'h11112222})
      $display("FAIL tie2_rd_value got=%0h exp=%0h", {rd_ready, rd_value}, {1'b1, 32'h11112222}); else passed++;
    tick;
  endtask

  task automatic test_reset_mid_access;
    rd_req = 1; rd_addr = 7'h20;
    tick;
    rd_req = 0;
    tick;
    total++; if ({reg_req, reg_addr} !== {1'b1, 7'h20}) $display("FAIL mid_access got=%0h exp=%0h", {reg_req, reg_addr}, {1'b1, 7'h20}); else passed++;
    rst = 1;
    tick;
    rst = 0;
    total++; if ({reg_req, reg_we, reg_addr, reg_wdata, reg_wstrb, wr_ready, wr_response, rd_ready, rd_response, rd_value} !== '0)
      $display("FAIL mid_reset_outputs got=%0h exp=0", {reg_req, reg_addr, rd_ready, rd_response, rd_value}); else passed++;
    reg_ack = 1;
    tick;
    reg_ack = 0;
    tick;
    total++; if ({reg_req, rd_ready, wr_ready} !== 3'b000)
      $display("FAIL mid_no_ready got=%0b exp=000", {reg_req, rd_ready, wr_ready}); else passed++;
    rd_req = 1; rd_addr = 7'h24;
    tick;
    rd_req = 0;
    tick;
    total++; if ({reg_req, reg_addr} !== {1'b1, 7'h24}) $display("FAIL mid_next_access got=%0h exp=%0h", {reg_req, reg_addr}, {1'b1, 7'h24}); else passed++;
    reg_ack = 1; reg_rdata = 32'h000055AA;
    tick;
    reg_ack = 0;
    total++; if ({rd_ready, rd_response, rd_value} !== {1'b1, 1'b0, 32'h000055AA})
      $display("FAIL mid_next_ready got=%0h exp=%0h", {rd_ready, rd_response, rd_value}, {1'b1, 1'b0, 32'h000055AA}); else passed++;
    tick;
  endtask

  task automatic test_pending_ignore;
    int start_pulses;
    start_pulses = wr_pulses;
    wr_req = 1; wr_addr = 7'h30; wr_data = 32'hD1D1D1D1; wr_strb = 4'h1;
    tick;
    wr_addr = 7'h34; wr_data = 32'hD2D2D2D2; wr_strb = 4'h2;
    tick;
    wr_req = 0;
    total++; if ({reg_addr, reg_wdata, reg_wstrb} !== {7'h30, 32'hD1D1D1D1, 4'h1})
      $display("FAIL pend_first_payload got=%0h exp=%0h", {reg_addr, reg_wdata, reg_wstrb}, {7'h30, 32'hD1D1D1D1, 4'h1}); else passed++;
    tick;
    reg_ack = 1; reg_err = 1;
    tick;
    reg_ack = 0; reg_err = 0;
    total++; if ({wr_ready, wr_response} !== 2'b11) $display("FAIL pend_wr_ready got=%0b exp=11", {wr_ready, wr_response}); else passed++;
    wr_req = 1; wr_addr = 7'h38; wr_data = 32'hD3D3D3D3; wr_strb = 4'h8;
    tick;
    wr_req = 0;
    total++; if ({wr_ready, reg_req} !== 2'b00) $display("FAIL pend_after_ready got=%0b exp=00", {wr_ready, reg_req}); else passed++;
    tick;
    total++; if ({reg_req, reg_addr, reg_wdata, reg_wstrb} !== {1'b1, 7'h38, 32'hD3D3D3D3, 4'h8})
      $display("FAIL pend_coincident_req got=%0h exp=%0h", {reg_req, reg_addr, reg_wdata, reg_wstrb}, {1'b1, 7'h38, 32'hD3D3D3D3, 4'h8}); else passed++;
    reg_ack = 1;
    tick;
    reg_ack = 0;
    total++; if ({wr_ready, wr_response} !== 2'b10) $display("FAIL pend_second_ready got=%0b exp=10", {wr_ready, wr_response}); else passed++;
    tick; tick;
    total++; if (wr_pulses - start_pulses !== 2) $display("FAIL pend_pulse_count got=%0d exp=2", wr_pulses - start_pulses); else passed++;
  endtask

  task automatic test_timeout;
    int hi;
    do_reset;
    t_rd_req = 1; t_rd_addr = 7'h0C;
    tick;
    t_rd_req = 0;
    tick;
    t_reg_ack = 1; t_reg_rdata = 32'hDEADBEEF;
    tick;
    t_reg_ack = 0; t_reg_rdata = 32'h12345678;
    total++; if ({t_rd_ready, t_rd_value} !== {1'b1, 32'hDEADBEEF})
      $display("FAIL to_pre_read got=%0h exp=%0h", {t_rd_ready, t_rd_value}, {1'b1, 32'hDEADBEEF}); else passed++;
    tick;
    t_rd_req = 1; t_rd_addr = 7'h0D;
    tick;
    t_rd_req = 0;
    tick;
    hi = 0;
    while (t_reg_req === 1'b1 && hi < 20) begin
      hi++;
      tick;
    end
    total++; if (hi !== 4) $display("FAIL to_req_cycles got=%0d exp=4", hi); else passed++;
    total++; if ({t_rd_ready, t_rd_response, t_rd_value} !== {1'b1, 1'b1, 32'h0})
      $display("FAIL to_slverr got=%0h exp=%0h", {t_rd_ready, t_rd_response, t_rd_value}, {1'b1, 1'b1, 32'h0}); else passed++;
    tick; tick;
    t_reg_ack = 1; t_reg_rdata = 32'h00000BAD;
    tick;
    t_reg_ack = 0;
    total++; if ({t_rd_ready, t_wr_ready, t_reg_req, t_rd_response, t_rd_value} !== {4'b0001, 32'h0})
      $display("FAIL to_late_ack got=%0h exp=%0h", {t_rd_ready, t_wr_ready, t_reg_req, t_rd_response, t_rd_value}, {4'b0001, 32'h0}); else passed++;
    tick;
    total++; if ({t_rd_ready, t_reg_req} !== 2'b00) $display("FAIL to_late_ack_after got=%0b exp=00", {t_rd_ready, t_reg_req}); else passed++;
  endtask

  initial begin
    do_reset;
    test_reset;
    test_write;
    test_read;
    test_tie;
    test_reset_mid_access;
    test_pending_ignore;
    test_timeout;
    total++; if (both_hi !== 0) $display("FAIL ready_exclusive got=%0d exp=0", both_hi); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
